// File: rtl/beat_detector_multi.sv
// Multi-channel accelerometer beat detector: short vs long moving average of |sample|,
// graded into three intensity tiers with refractory hold-off and a warm-up flag.
module beat_detector_multi #(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 16,
    parameter int LONG_LOG2  = 7,
    parameter int SHORT_LOG2 = 3,
    parameter int TH1        = 3,
    parameter int TH2        = 6,
    parameter int TH3        = 8,
    parameter int REFRACT    = 16
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            clear,
    input  logic                                            sample_valid,
    input  logic [NUM_CH*DATA_W-1:0]                        sample_data,
    output logic                                            warm,
    output logic                                            beat_en,
    output logic [1:0]                                      beat_intensity,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  beat_ch
);
    localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH  = 1 << LONG_LOG2;
    localparam int SDEPTH = 1 << SHORT_LOG2;
    localparam int LW     = DATA_W + LONG_LOG2;
    localparam int SW     = DATA_W + SHORT_LOG2;
    localparam int CW     = LONG_LOG2 + 1;
    localparam int PW     = DATA_W + 6;
    localparam int RW     = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic [DATA_W-1:0]              hist_q [NUM_CH][DEPTH];
    logic [NUM_CH-1:0][DATA_W-1:0]  smp;
    logic [NUM_CH-1:0][DATA_W-1:0]  mag;
    logic [NUM_CH-1:0][LW-1:0]      long_q, long_d;
    logic [NUM_CH-1:0][SW-1:0]      short_q, short_d;
    logic [LONG_LOG2-1:0]           wr_ptr_q, old_ptr_s;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           long_full, short_full;
    logic                           warm_q, v1_q;
    logic [RW-1:0]                  refr_q, refr_d;
    logic                           beat_q, beat_d;
    logic [1:0]                     int_q, int_d;
    logic [CHW-1:0]                 ch_q, ch_d;

    logic [NUM_CH-1:0][DATA_W-1:0]  l_avg, s_avg;
    logic [NUM_CH-1:0][PW-1:0]      d16;
    logic [NUM_CH-1:0][1:0]         tier;
    logic [1:0]                     best_tier;
    logic [CHW-1:0]                 best_ch;

    assign smp = sample_data;

    // History is never flushed; entries not yet written since reset/clear are masked by the fill count.
    always_comb begin
        old_ptr_s  = wr_ptr_q - LONG_LOG2'(SDEPTH);
        long_full  = (cnt_q == CW'(DEPTH));
        short_full = (cnt_q >= CW'(SDEPTH));
        cnt_d      = long_full ? cnt_q : cnt_q + CW'(1);
        mag        = '0;
        long_d     = '0;
        short_d    = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (smp[c] == {1'b1, {(DATA_W-1){1'b0}}})
                mag[c] = {1'b0, {(DATA_W-1){1'b1}}};
            else if (smp[c][DATA_W-1])
                mag[c] = -smp[c];
            else
                mag[c] = smp[c];
            long_d[c]  = long_q[c] + LW'(mag[c])
                         - (long_full ? LW'(hist_q[c][wr_ptr_q]) : '0);
            short_d[c] = short_q[c] + SW'(mag[c])
                         - (short_full ? SW'(hist_q[c][old_ptr_s]) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && sample_valid && !clear) begin
            for (int unsigned c = 0; c < NUM_CH; c++)
                hist_q[c][wr_ptr_q] <= mag[c];
        end
    end

    always_comb begin
        l_avg     = '0;
        s_avg     = '0;
        d16       = '0;
        tier      = '0;
        best_tier = '0;
        best_ch   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            l_avg[c] = DATA_W'(long_q[c] >> LONG_LOG2);
            s_avg[c] = DATA_W'(short_q[c] >> SHORT_LOG2);
            if (s_avg[c] > l_avg[c]) begin
                d16[c] = PW'(s_avg[c] - l_avg[c]) << 4;
                if (d16[c] >= PW'(TH3) * PW'(l_avg[c]))
                    tier[c] = 2'd3;
                else if (d16[c] >= PW'(TH2) * PW'(l_avg[c]))
                    tier[c] = 2'd2;
                else if (d16[c] >= PW'(TH1) * PW'(l_avg[c]))
                    tier[c] = 2'd1;
            end
            if (tier[c] > best_tier) begin
                best_tier = tier[c];
                best_ch   = CHW'(c);
            end
        end
    end

    always_comb begin
        beat_d = 1'b0;
        int_d  = '0;
        ch_d   = '0;
        refr_d = refr_q;
        if (v1_q) begin
            if (refr_q != '0) begin
                refr_d = refr_q - RW'(1);
            end else if (warm_q && best_tier != 2'd0) begin
                beat_d = 1'b1;
                int_d  = best_tier;
                ch_d   = best_ch;
                refr_d = RW'(REFRACT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_q   <= '0;
            short_q  <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            warm_q   <= 1'b0;
            v1_q     <= 1'b0;
            refr_q   <= '0;
            beat_q   <= 1'b0;
            int_q    <= '0;
            ch_q     <= '0;
        end else if (clear) begin
            long_q   <= '0;
            short_q  <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            warm_q   <= 1'b0;
            v1_q     <= 1'b0;
            refr_q   <= '0;
            beat_q   <= 1'b0;
            int_q    <= '0;
            ch_q     <= '0;
        end else begin
            v1_q   <= sample_valid;
            refr_q <= refr_d;
            beat_q <= beat_d;
            int_q  <= int_d;
            ch_q   <= ch_d;
            if (sample_valid) begin
                long_q   <= long_d;
                short_q  <= short_d;
                wr_ptr_q <= wr_ptr_q + LONG_LOG2'(1);
                cnt_q    <= cnt_d;
                warm_q   <= warm_q | (cnt_d == CW'(DEPTH));
            end
        end
    end

    assign warm           = warm_q;
    assign beat_en        = beat_q;
    assign beat_intensity = int_q;
    assign beat_ch        = ch_q;

endmodule

// File: tb/tb_beat_detector_multi.sv
// Directed bench for beat_detector_multi: per-cycle comparison against a window-sum model
// plus literal expectations for warm-up timing, tier grading, saturation and flushes.
module tb_beat_detector_multi;
    localparam int NCH  = 3;
    localparam int DW   = 16;
    localparam int REFR = 16;
    localparam int T1   = 3;
    localparam int T2   = 6;
    localparam int T3   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              sample_valid;
    logic [NCH*DW-1:0] sample_data;
    logic              warm;
    logic              beat_en;
    logic [1:0]        beat_intensity;
    logic [1:0]        beat_ch;

    beat_detector_multi #(
        .NUM_CH(NCH), .DATA_W(DW), .LONG_LOG2(7), .SHORT_LOG2(3),
        .TH1(T1), .TH2(T2), .TH3(T3), .REFRACT(REFR)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid),
        .sample_data(sample_data), .warm(warm), .beat_en(beat_en),
        .beat_intensity(beat_intensity), .beat_ch(beat_ch)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int beats_seen = 0;

    int unsigned hist [NCH][$];
    int  cnt_m, refr_m;
    bit  pend_beat, exp_warm, exp_beat;
    int  pend_int, pend_ch, exp_int, exp_ch;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic logic [NCH*DW-1:0] pack(input int a, input int b, input int c);
        logic [DW-1:0] x0, x1, x2;
        x0 = DW'(a);
        x1 = DW'(b);
        x2 = DW'(c);
        return {x2, x1, x0};
    endfunction

    function automatic int unsigned magof(input logic [DW-1:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) hist[c].delete();
        cnt_m = 0; refr_m = 0;
        pend_beat = 0; pend_int = 0; pend_ch = 0;
        exp_warm = 0; exp_beat = 0; exp_int = 0; exp_ch = 0;
    endtask

    // Averages recomputed from scratch over the retained magnitudes each sample.
    task automatic model_accept(input logic [NCH*DW-1:0] data);
        int best, bch, tr, n, st;
        int unsigned lsum, ssum, lavg, savg, d;
        for (int c = 0; c < NCH; c++) begin
            hist[c].push_back(magof(data[c*DW +: DW]));
            if (hist[c].size() > 128) void'(hist[c].pop_front());
        end
        if (cnt_m < 128) cnt_m++;
        exp_warm = (cnt_m == 128);
        best = 0; bch = 0;
        for (int c = 0; c < NCH; c++) begin
            n = hist[c].size();
            st = (n > 8) ? n - 8 : 0;
            lsum = 0; ssum = 0;
            for (int i = 0; i < n; i++) lsum += hist[c][i];
            for (int i = st; i < n; i++) ssum += hist[c][i];
            lavg = lsum / 128;
            savg = ssum / 8;
            tr = 0;
            if (savg > lavg) begin
                d = savg - lavg;
                if (16 * d >= T3 * lavg) tr = 3;
                else if (16 * d >= T2 * lavg) tr = 2;
                else if (16 * d >= T1 * lavg) tr = 1;
            end
            if (tr > best) begin best = tr; bch = c; end
        end
        pend_beat = 0; pend_int = 0; pend_ch = 0;
        if (refr_m > 0) refr_m--;
        else if (cnt_m == 128 && best > 0) begin
            pend_beat = 1; pend_int = best; pend_ch = bch; refr_m = REFR;
        end
    endtask

    task automatic step(input bit v, input logic [NCH*DW-1:0] data, input bit clr);
        sample_valid = v;
        sample_data  = data;
        clear        = clr;
        @(posedge clk);
        #1;
        if (clr) model_clear();
        else begin
            exp_beat = pend_beat; exp_int = pend_int; exp_ch = pend_ch;
            if (v) model_accept(data);
            else begin pend_beat = 0; pend_int = 0; pend_ch = 0; end
        end
        chk("warm", warm, exp_warm);
        chk("beat_en", beat_en, exp_beat);
        chk("beat_intensity", beat_intensity, exp_int);
        chk("beat_ch", beat_ch, exp_ch);
        if (beat_en) beats_seen++;
        sample_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_async_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_async_warm", warm, 0);
        chk("rst_async_beat", beat_en, 0);
        chk("rst_async_int", beat_intensity, 0);
        chk("rst_async_ch", beat_ch, 0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_case(input logic [NCH*DW-1:0] base, input logic [NCH*DW-1:0] hi,
                            input int lit_ch, input bit gaps);
        beats_seen = 0;
        for (int i = 1; i <= 128; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(0, '0, 0);
            step(1, base, 0);
        end
        for (int i = 1; i <= 25; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(0, '0, 0);
            step(1, hi, 0);
            if (!gaps && i == 2) chk("lit_hi1_nobeat", beat_en, 0);
            if (!gaps && i == 3) begin
                chk("lit_hi2_beat", beat_en, 1);
                chk("lit_hi2_int", beat_intensity, 1);
                chk("lit_hi2_ch", beat_ch, lit_ch);
            end
            if (!gaps && i == 19) chk("lit_hi18_suppressed", beat_en, 0);
            if (!gaps && i == 20) begin
                chk("lit_hi19_beat", beat_en, 1);
                chk("lit_hi19_int", beat_intensity, 3);
                chk("lit_hi19_ch", beat_ch, lit_ch);
            end
        end
        step(0, '0, 0);
        step(0, '0, 0);
        chk("lit_beat_count", beats_seen, 2);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_warm", warm, 0);
        chk("reset_beat", beat_en, 0);
        chk("reset_int", beat_intensity, 0);
        chk("reset_ch", beat_ch, 0);
        rst = 1'b1;

        beats_seen = 0;
        for (int i = 1; i <= 300; i++) begin
            step(1, pack(1000, 1000, 1000), 0);
            if (i == 127) chk("t1_warm_at_127", warm, 0);
            if (i == 128) chk("t1_warm_at_128", warm, 1);
        end
        step(0, '0, 0);
        chk("t1_no_beats", beats_seen, 0);

        step(1, pack(9, 9, 9), 1);
        chk("clear_drops_warm", warm, 0);
        run_case(pack(1000, 1000, 1000), pack(1000, 2000, 1000), 1, 0);

        step(1, pack(5, 5, 5), 1);
        run_case(pack(1000, 1000, 1000), pack(-2000, 1000, -2000), 0, 0);

        step(0, '0, 1);
        run_case(pack(1000, 1000, 1000), pack(1000, 2000, 1000), 1, 1);

        // Sits one LSB of 16*S below the tier-1 boundary only if -32768 saturates to 32767.
        step(0, '0, 1);
        for (int i = 1; i <= 128; i++) step(1, pack(12504, 12504, 12504), 0);
        step(1, pack(-32768, 12504, 12504), 0);
        step(0, '0, 0);
        chk("lit_sat_nobeat", beat_en, 0);
        for (int i = 1; i <= 8; i++) step(1, pack(-32768, 12504, 12504), 0);
        step(0, '0, 0);

        step(0, '0, 1);
        for (int i = 1; i <= 128; i++) step(1, pack(1000, 1000, 1000), 0);
        step(1, pack(1000, 2000, 1000), 0);
        step(1, pack(1000, 2000, 1000), 0);
        do_async_reset();
        step(0, '0, 0);
        step(0, '0, 0);
        chk("rst_pending_dropped", beat_en, 0);
        for (int i = 1; i <= 128; i++) begin
            step(1, pack(1000, 1000, 1000), 0);
            if (i == 127) chk("rst_warm_at_127", warm, 0);
            if (i == 128) chk("rst_warm_at_128", warm, 1);
        end
        step(0, '0, 1);
        chk("clear_warm_next_edge", warm, 0);
        for (int i = 1; i <= 70; i++) step(1, pack(1000, 1000, 1000), 0);
        step(1, pack(1000, 1000, 1000), 1);
        for (int i = 1; i <= 128; i++) begin
            step(1, pack(1000, 1000, 1000), 0);
            if (i == 127) chk("clr_warm_at_127", warm, 0);
            if (i == 128) chk("clr_warm_at_128", warm, 1);
        end
        step(0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/beat_detector_multi.md
Name: beat_detector_multi

Overview:
- Parametrised multi-channel beat detector for accelerometer streams.
- Per channel, it compares a short moving average of |sample| against a long moving average. It raises a one-cycle beat pulse with a 2-bit intensity and the index of the triggering channel.
- Sits between the accelerometer sample interface and the beat/LED/audio consumers.
- Adds over the previous generation: arbitrary channel count, sample-valid qualification, warm-up flag, highest-tier-first intensity grading, refractory hold-off, synchronous clear.

Parameters:
- NUM_CH, 3: number of channels.
- DATA_W, 16: sample width; signed two's complement.
- LONG_LOG2, 7: long window = 2^LONG_LOG2 accepted samples.
- SHORT_LOG2, 3: short window = 2^SHORT_LOG2 most recent samples; must be < LONG_LOG2.
- TH1, 3: tier-1 threshold in 1/16 units of long average.
- TH2, 6: tier-2 threshold in 1/16 units; must satisfy TH1 < TH2 < TH3.
- TH3, 8: tier-3 threshold in 1/16 units.
- REFRACT, 16: accepted samples suppressed after a beat; 0 disables hold-off.

Ports:
- clk, in, 1: clock; all logic rises on posedge.
- rst, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous flush, equivalent to reset; has priority over sample_valid.
- sample_valid, in, 1: sample_data accepted on any cycle it is high; back-to-back allowed.
- sample_data, in, NUM_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- warm, out, 1: long window full; detection active.
- beat_en, out, 1: one-cycle beat pulse.
- beat_intensity, out, 2: 1/2/3 = tier; 0 when beat_en is low.
- beat_ch, out, clog2(NUM_CH) (min 1): triggering channel; 0 when beat_en is low.

Behaviour:
- Reset / clear:
  - All outputs 0.
  - Sums, buffers, sample counter and refractory counter cleared.
  - Reset mid-operation discards all history; warm-up restarts from zero.
- Magnitude:
  - m = |sample|, unsigned DATA_W bits.
  - Most-negative input saturates to 2^(DATA_W-1)-1.
- Windows:
  - Per channel, a circular history of 2^LONG_LOG2 magnitudes.
  - Long sum and short sum kept incrementally: add new, subtract the sample leaving each window.
  - Long sum width DATA_W+LONG_LOG2; short sum width DATA_W+SHORT_LOG2; no overflow possible.
  - Averages are sums right-shifted by LOG2 (floor).
  - Buffer entries before fill read as 0.
- Pipeline: a sample accepted in cycle t updates the sums at t+1 and produces its decision on beat_en at t+2. Outputs are registered.
- Warm-up:
  - Accepted-sample counter saturates at 2^LONG_LOG2.
  - warm rises together with the sums update of the 2^LONG_LOG2-th accepted sample.
  - That sample is the first one evaluated; earlier samples never produce a beat.
- Grading, per channel, with L = long avg and S = short avg:
  - d = S - L, signed.
  - Channel qualifies only if d > 0.
  - Tier 3 if 16*d >= TH3*L; else tier 2 if 16*d >= TH2*L; else tier 1 if 16*d >= TH1*L; else tier 0.
  - Comparisons are exact, with DATA_W+6-bit products; no division.
- Channel selection:
  - Reported intensity is the maximum tier across channels.
  - beat_ch is the lowest-index channel holding that tier.
- Refractory hold-off:
  - A beat on an evaluated sample loads the counter with REFRACT.
  - Each later accepted sample decrements it, and is forced to no-beat while the counter is nonzero before the decrement.
  - So with REFRACT=16, samples k+1 through k+16 are suppressed and k+17 may fire.
- Idle cycles (sample_valid low) change nothing; beat_en low.
- clear and sample_valid in the same cycle: clear wins and the sample is dropped.

Test Plan:
1. Constant 1000 on all channels for 300 samples → warm rises 1 cycle after sample 128 is accepted; beat_en stays 0 throughout.
2. After 128×1000, channel 1 steps to 2000, others stay 1000:
   - 1st high sample: no beat (16·118=1888 < 3·1007).
   - 2nd high sample: beat_en=1, intensity=1, beat_ch=1, 2 cycles after acceptance (S=1250, L=1015).
3. Continue case 2 with REFRACT=16:
   - High samples 3–18: no beat.
   - 19th high sample: beat_en=1, intensity=3, beat_ch=1 (S=2000, L=1148).
4. Case 2 repeated with channels 0 and 2 both stepping to -2000 → same timing and intensity, beat_ch=0. Also drive -32768 to check saturation to 32767.
5. Gaps: insert random idle cycles in case 2 → decisions identical per accepted sample; beat_en only 2 cycles after a valid.
6. Flush mid-stream: assert rst (async, mid-cycle) and separately clear at sample 70 of warm-up → outputs 0 immediately (rst) or next edge (clear); warm needs a full 128 new samples; no beat in between.
